// File: rtl/mem_seq.sv
// mem_seq: load/store sequencer in front of the MMU/SRAM stage.
//
// Accepts byte/half/word requests from the core (valid/ready), issues only
// word-aligned single-word accesses downstream (plain read, plain write, or
// read-modify-write for sub-word stores) and returns extracted, zero- or
// sign-extended load data or an error flag over a response handshake.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   REQ_*                 core request channel (REQ_READY high only in IDLE)
//   RSP_*                 response channel, held stable until RSP_READY
//   MEM_ADDR/MEM_IN       word address and write data to the MMU
//   MEM_N_OE/MEM_N_WE     active-low read / write strobes, never both low
//   MEM_OUT               read data, valid whenever MEM_N_OE = 0
//   STAT_*                response counters
//
// Optional feature macro: MEM_SEQ_STATS_EN. When defined, STAT_LOADS,
// STAT_STORES and STAT_ERRS count response handshakes and saturate. When
// undefined the counter ports are tied to 0.
//
// state | meaning
// IDLE  | ready for a request; classify and launch on REQ_VALID
// READ  | MEM_N_OE low for one cycle, MEM_OUT captured at the closing edge
// WRITE | MEM_N_WE low for one cycle with the (merged) word on MEM_IN
// RESP  | response presented until RSP_READY
module mem_seq #(
  parameter int MEM_BYTES = 4096,
  parameter int STAT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [31:0]       REQ_ADDR,
  input  logic              REQ_WE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_SIGNED,
  input  logic [31:0]       REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_DATA,
  output logic              RSP_ERR,
  output logic [31:0]       MEM_ADDR,
  output logic              MEM_N_OE,
  output logic              MEM_N_WE,
  output logic [31:0]       MEM_IN,
  input  logic [31:0]       MEM_OUT,
  output logic [STAT_W-1:0] STAT_LOADS,
  output logic [STAT_W-1:0] STAT_STORES,
  output logic [STAT_W-1:0] STAT_ERRS
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic [1:0]  lane;
  logic [1:0]  size;
  logic        we;
  logic        sgn;
  logic [31:0] wdata;
  logic        req_bad;

  always_comb begin
    req_bad = 1'b0;
    if (REQ_SIZE == 2'd3)                          req_bad = 1'b1;
    if (REQ_SIZE == 2'd1 && REQ_ADDR[0])           req_bad = 1'b1;
    if (REQ_SIZE == 2'd2 && REQ_ADDR[1:0] != 2'b0) req_bad = 1'b1;
    if (REQ_ADDR >= 32'(MEM_BYTES))                req_bad = 1'b1;
  end

  // Little-endian lane extraction with optional sign extension.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    extract = {{24{sg & b[7]}}, b};
      2'd1:    extract = {{16{sg & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the captured word.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] a, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      2'd0: r[{a, 3'b000} +: 8] = d[7:0];
      2'd1: if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
      default: r = d;
    endcase
    merge = r;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 32'h0;
      RSP_ERR   <= 1'b0;
      MEM_ADDR  <= 32'h0;
      MEM_N_OE  <= 1'b1;
      MEM_N_WE  <= 1'b1;
      MEM_IN    <= 32'h0;
      lane      <= 2'b0;
      size      <= 2'b0;
      we        <= 1'b0;
      sgn       <= 1'b0;
      wdata     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            REQ_READY <= 1'b0;
            lane      <= REQ_ADDR[1:0];
            size      <= REQ_SIZE;
            we        <= REQ_WE;
            sgn       <= REQ_SIGNED;
            wdata     <= REQ_DATA;
            if (req_bad) begin
              state     <= RESP;
              RSP_VALID <= 1'b1;
              RSP_ERR   <= 1'b1;
              RSP_DATA  <= 32'h0;
            end else if (REQ_WE && REQ_SIZE == 2'd2) begin
              state    <= WRITE;
              MEM_ADDR <= {REQ_ADDR[31:2], 2'b00};
              MEM_IN   <= REQ_DATA;
              MEM_N_WE <= 1'b0;
            end else begin
              state    <= READ;
              MEM_ADDR <= {REQ_ADDR[31:2], 2'b00};
              MEM_N_OE <= 1'b0;
            end
          end
        end
        READ: begin
          MEM_N_OE <= 1'b1;
          if (we) begin
            state    <= WRITE;
            MEM_IN   <= merge(MEM_OUT, wdata, lane, size);
            MEM_N_WE <= 1'b0;
          end else begin
            state     <= RESP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b0;
            RSP_DATA  <= extract(MEM_OUT, lane, size, sgn);
          end
        end
        WRITE: begin
          MEM_N_WE  <= 1'b1;
          state     <= RESP;
          RSP_VALID <= 1'b1;
          RSP_ERR   <= 1'b0;
          RSP_DATA  <= 32'h0;
        end
        default: begin
          if (RSP_READY) begin
            state     <= IDLE;
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef MEM_SEQ_STATS_EN
  logic [STAT_W-1:0] n_loads, n_stores, n_errs;
  logic              rsp_fire;

  assign rsp_fire = (state == RESP) && RSP_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_loads  <= '0;
      n_stores <= '0;
      n_errs   <= '0;
    end else if (rsp_fire) begin
      if (RSP_ERR) begin
        if (~&n_errs) n_errs <= n_errs + 1'b1;
      end else if (we) begin
        if (~&n_stores) n_stores <= n_stores + 1'b1;
      end else begin
        if (~&n_loads) n_loads <= n_loads + 1'b1;
      end
    end
  end

  assign STAT_LOADS  = n_loads;
  assign STAT_STORES = n_stores;
  assign STAT_ERRS   = n_errs;
`else
  assign STAT_LOADS  = '0;
  assign STAT_STORES = '0;
  assign STAT_ERRS   = '0;
`endif

endmodule

// File: tb/tb_mem_seq.sv
// Directed testbench for mem_seq with a small word-array memory model.
module tb_mem_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_n_oe, mem_n_we;
  logic [31:0] mem_in, mem_out;
  logic [15:0] stat_loads, stat_stores, stat_errs;

  logic [31:0] mem [0:1023];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign mem_out = mem[mem_addr[11:2]];
  always @(posedge clk) if (!mem_n_we) mem[mem_addr[11:2]] <= mem_in;

  mem_seq #(.MEM_BYTES(4096), .STAT_W(16)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_ADDR(req_addr),
    .REQ_WE(req_we), .REQ_SIZE(req_size), .REQ_SIGNED(req_signed), .REQ_DATA(req_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .MEM_ADDR(mem_addr), .MEM_N_OE(mem_n_oe), .MEM_N_WE(mem_n_we),
    .MEM_IN(mem_in), .MEM_OUT(mem_out),
    .STAT_LOADS(stat_loads), .STAT_STORES(stat_stores), .STAT_ERRS(stat_errs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, track the downstream strobes until the response,
  // optionally hold off RSP_READY, then complete the handshake.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] data,
                        input int exp_lat, input int exp_oe, input int exp_we,
                        input logic [31:0] exp_min, input logic [31:0] exp_data,
                        input logic exp_err, input int hold);
    int c, n_oe, n_we, n_both, w;
    logic [31:0] acc_addr, seen_min;
    w = 0;
    while (!req_ready && w < 20) begin step(); w++; end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_data = data;
    step();
    req_valid = 1'b0;
    c = 1; n_oe = 0; n_we = 0; n_both = 0;
    acc_addr = 32'hx; seen_min = 32'hx;
    while (!rsp_valid && c < 10) begin
      if (!mem_n_oe) begin n_oe++; acc_addr = mem_addr; end
      if (!mem_n_we) begin n_we++; acc_addr = mem_addr; seen_min = mem_in; end
      if (!mem_n_oe && !mem_n_we) n_both++;
      step();
      c++;
    end
    check({tag, " latency"}, 32'(c), 32'(exp_lat));
    check({tag, " oe_cycles"}, 32'(n_oe), 32'(exp_oe));
    check({tag, " we_cycles"}, 32'(n_we), 32'(exp_we));
    check({tag, " both_low"}, 32'(n_both), 32'd0);
    if (exp_oe + exp_we > 0) check({tag, " mem_addr"}, acc_addr, {addr[31:2], 2'b00});
    if (exp_we > 0) check({tag, " mem_in"}, seen_min, exp_min);
    check({tag, " rsp_data"}, rsp_data, exp_data);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, " busy"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold_data"}, rsp_data, exp_data);
      check({tag, " hold_busy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #12;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", rsp_data, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst n_oe", 32'(mem_n_oe), 32'd1);
    check("rst n_we", 32'(mem_n_we), 32'd1);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_in", mem_in, 32'h0);
    check("rst stat_loads", 32'(stat_loads), 32'd0);
    rst = 1'b0;
    step();

    //      tag         we   sz  sg   addr    data     lat oe we mem_in       rsp_data   err hold
    do_req("sw 100",    1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 2, 0, 1, 32'hDEADBEEF, 32'h0,       0, 0);
    do_req("lw 100",    0, 2'd2, 0, 32'h100, 32'h0,        2, 1, 0, 32'h0,        32'hDEADBEEF, 0, 0);
    do_req("sb 102",    1, 2'd0, 0, 32'h102, 32'hFFFFFF5A, 3, 1, 1, 32'hDE5ABEEF, 32'h0,       0, 0);
    do_req("lb s 103",  0, 2'd0, 1, 32'h103, 32'h0,        2, 1, 0, 32'h0,        32'hFFFFFFDE, 0, 0);
    do_req("lh u 100",  0, 2'd1, 0, 32'h100, 32'h0,        2, 1, 0, 32'h0,        32'h0000BEEF, 0, 0);
    do_req("lh s 102",  0, 2'd1, 1, 32'h102, 32'h0,        2, 1, 0, 32'h0,        32'hFFFFDE5A, 0, 0);
    do_req("lb u 102",  0, 2'd0, 0, 32'h102, 32'h0,        2, 1, 0, 32'h0,        32'h0000005A, 0, 0);
    do_req("lw s 100",  0, 2'd2, 1, 32'h100, 32'h0,        2, 1, 0, 32'h0,        32'hDE5ABEEF, 0, 0);
    do_req("lh 101",    0, 2'd1, 0, 32'h101, 32'h0,        1, 0, 0, 32'h0,        32'h0,       1, 0);
    do_req("sw 102",    1, 2'd2, 0, 32'h102, 32'h12345678, 1, 0, 0, 32'h0,        32'h0,       1, 0);
    do_req("size3",     0, 2'd3, 0, 32'h100, 32'h0,        1, 0, 0, 32'h0,        32'h0,       1, 0);
    do_req("lw 1000",   0, 2'd2, 0, 32'h1000, 32'h0,       1, 0, 0, 32'h0,        32'h0,       1, 0);
    do_req("bp lb 101", 0, 2'd0, 1, 32'h101, 32'h0,        2, 1, 0, 32'h0,        32'hFFFFFFBE, 0, 5);
    do_req("sh 102",    1, 2'd1, 0, 32'h102, 32'hABCD1234, 3, 1, 1, 32'h1234BEEF, 32'h0,       0, 0);

    // Reset in the WRITE cycle of a byte store: write aborted, no response.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h100; req_data = 32'h77;
    step();
    req_valid = 1'b0;
    check("rmw read", 32'(mem_n_oe), 32'd0);
    step();
    check("rmw write", 32'(mem_n_we), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst n_we", 32'(mem_n_we), 32'd1);
    check("rst rsp_valid mid", 32'(rsp_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("rst no rsp", 32'(rsp_valid), 32'd0);
    check("rst ready", 32'(req_ready), 32'd1);
    do_req("lw after rst", 0, 2'd2, 0, 32'h100, 32'h0, 2, 1, 0, 32'h0, 32'h1234BEEF, 0, 0);

    // Fresh counters: 3 loads, 2 stores, 1 error.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("stat clr", 32'(stat_loads) + 32'(stat_stores) + 32'(stat_errs), 32'd0);
    do_req("st ld1", 0, 2'd2, 0, 32'h100, 32'h0,  2, 1, 0, 32'h0,  32'h1234BEEF, 0, 0);
    do_req("st sw",  1, 2'd2, 0, 32'h104, 32'h55, 2, 0, 1, 32'h55, 32'h0,       0, 0);
    do_req("st ld2", 0, 2'd0, 0, 32'h104, 32'h0,  2, 1, 0, 32'h0,  32'h00000055, 0, 0);
    do_req("st err", 0, 2'd1, 0, 32'h103, 32'h0,  1, 0, 0, 32'h0,  32'h0,       1, 0);
    do_req("st sb",  1, 2'd0, 0, 32'h105, 32'h66, 3, 1, 1, 32'h6655, 32'h0,     0, 0);
    do_req("st ld3", 0, 2'd1, 0, 32'h104, 32'h0,  2, 1, 0, 32'h0,  32'h00006655, 0, 0);
`ifdef MEM_SEQ_STATS_EN
    check("stat loads",  32'(stat_loads),  32'd3);
    check("stat stores", 32'(stat_stores), 32'd2);
    check("stat errs",   32'(stat_errs),   32'd1);
`else
    check("stat loads",  32'(stat_loads),  32'd0);
    check("stat stores", 32'(stat_stores), 32'd0);
    check("stat errs",   32'(stat_errs),   32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Load/store sequencer directly upstream of the MMU/SRAM stage.
- Accepts byte, halfword and word requests from the core over a valid/ready handshake.
- Issues only word-aligned single-word accesses downstream: plain reads, plain writes, or read-modify-write for sub-word stores.
- Returns extracted, sign- or zero-extended load data, or an error flag, over a response handshake.

Parameters:
- MEM_BYTES, 4096: size of backing memory in bytes; any REQ_ADDR >= MEM_BYTES is an error.
- STAT_W, 16: width of the optional statistics counters.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_ADDR  in  32  byte address.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- REQ_SIGNED  in  1  sign-extend load result.
- REQ_DATA  in  32  store data, right-justified.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts response.
- RSP_DATA  out  32  load result; 0 for stores and errors.
- RSP_ERR  out  1  misaligned, out-of-range or reserved-size request.
- MEM_ADDR  out  32  word address to MMU; bits [1:0] always 0.
- MEM_N_OE  out  1  active-low read enable.
- MEM_N_WE  out  1  active-low write enable.
- MEM_IN  out  32  write data to MMU.
- MEM_OUT  in  32  read data from MMU, valid in any cycle MEM_N_OE = 0.
- STAT_LOADS, STAT_STORES, STAT_ERRS  out  STAT_W each  optional counters.

Behaviour:
- Reset (async, immediate): state IDLE.
  - MEM_N_OE = MEM_N_WE = 1, MEM_ADDR = 0, MEM_IN = 0.
  - RSP_VALID = 0, RSP_DATA = 0, RSP_ERR = 0, counters = 0.
  - Any in-flight request is discarded with no response.
- All outputs are registered. MEM_N_OE and MEM_N_WE are never both 0.
- States: IDLE, READ, WRITE, RESP.
- IDLE: REQ_READY = 1 (REQ_READY = 1 only in IDLE). On REQ_VALID, latch the request, then:
  - Error if REQ_SIZE = 3, or half with ADDR[0] = 1, or word with ADDR[1:0] != 0, or ADDR >= MEM_BYTES. Go to RESP with RSP_ERR = 1; no memory access.
  - Load, or byte/half store: go to READ.
  - Word store: go to WRITE.
- READ (1 cycle): MEM_N_OE = 0, MEM_ADDR = {ADDR[31:2], 2'b00}. MEM_OUT is captured at the closing edge.
  - Load: go to RESP with the extracted data.
  - Sub-word store: go to WRITE.
- WRITE (1 cycle): MEM_N_WE = 0, MEM_ADDR held, MEM_IN = merged word. Go to RESP.
- Merge and extract lanes: little-endian; byte lane = ADDR[1:0] (bits 8k+7:8k), half lane = ADDR[1].
  - Store replaces only the addressed lane(s) of the captured word.
  - Load extracts the lane and zero- or sign-extends it per REQ_SIGNED. REQ_SIGNED is ignored for word loads and for stores.
- RESP: RSP_VALID = 1 and RSP_DATA/RSP_ERR are held stable until RSP_READY; then return to IDLE.
  - No new request is accepted in the RSP_READY cycle; the next accept is at the earliest one cycle later.
- Latency, accept edge to RSP_VALID: error 1 cycle; load 2; word store 2; sub-word store 3.
- MEM_ADDR and MEM_IN hold their last values outside READ and WRITE.

Optional Feature:
- Macro MEM_SEQ_STATS_EN.
- Defined: STAT_LOADS, STAT_STORES and STAT_ERRS increment on each response handshake (RSP_VALID && RSP_READY) of the matching kind. Errors count only in STAT_ERRS. Counters saturate at all-ones.
- Undefined: the counter ports remain present and are tied to 0; no counter flops are synthesised.

Test Plan:
- Word store 0x100 = 0xDEADBEEF, then word load 0x100 -> RSP_DATA = 0xDEADBEEF, RSP_ERR = 0. RSP_VALID rises 2 cycles after each accept. MEM_N_WE is low exactly one cycle.
- Byte store 0x5A to 0x102 over 0xDEADBEEF -> READ then WRITE with MEM_IN = 0xDE5ABEEF. Then signed byte load 0x103 -> 0xFFFFFFDE; unsigned half load 0x100 -> 0x0000BEEF.
- Half load at 0x101; word store at 0x102; REQ_SIZE = 3; load at 0x1000 -> RSP_ERR = 1 after 1 cycle, RSP_DATA = 0, MEM_N_OE and MEM_N_WE stay 1 throughout.
- Backpressure: hold RSP_READY = 0 for 5 cycles after a load response -> RSP_VALID and RSP_DATA stable, REQ_READY = 0 throughout; one cycle after release REQ_READY = 1.
- Assert RST during the WRITE cycle of a sub-word store -> MEM_N_WE = 1 immediately, no response. A following load returns the old word unchanged.
- With MEM_SEQ_STATS_EN: 3 loads, 2 stores, 1 error -> STAT_LOADS = 3, STAT_STORES = 2, STAT_ERRS = 1. Without the macro all counters read 0.
